// File: rtl/escalonador_melodia.sv
// Melody playback sequencer: walks note ROM addresses 0..limite, holds each
// note on arduino_out for TEMPO_NOTA cycles, follows it with TEMPO_PAUSA
// cycles of silence, and pulses pronto once the last note has finished.
module escalonador_melodia #(
   parameter int unsigned TEMPO_NOTA  = 25000000,
   parameter int unsigned TEMPO_PAUSA = 5000000,
   parameter int unsigned ADDR_W      = 4,
   parameter int unsigned NOTE_W      = 3
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              iniciar,
   input  logic              abortar,
   input  logic [ADDR_W-1:0] limite,
   input  logic [NOTE_W-1:0] nota_mem,
   output logic [ADDR_W-1:0] endereco,
   output logic [NOTE_W-1:0] arduino_out,
   output logic              tocando,
   output logic              pronto,
   output logic [2:0]        db_estado
);

   localparam int unsigned TEMPO_MAX = (TEMPO_NOTA > TEMPO_PAUSA) ? TEMPO_NOTA : TEMPO_PAUSA;
   localparam int unsigned TIMER_W   = $clog2(TEMPO_MAX + 1);

   localparam logic [TIMER_W-1:0] ULTIMO_NOTA  = TIMER_W'(TEMPO_NOTA - 1);
   localparam logic [TIMER_W-1:0] ULTIMO_PAUSA = TIMER_W'(TEMPO_PAUSA - 1);

   typedef enum logic [2:0] {
      OCIOSO   = 3'd0,
      ENDERECA = 3'd1,
      CARREGA  = 3'd2,
      TOCA     = 3'd3,
      PAUSA    = 3'd4,
      FIM      = 3'd5
   } estado_t;

   estado_t             estado;
   estado_t             prox_estado;
   logic [TIMER_W-1:0]  timer;
   logic [ADDR_W-1:0]   limite_reg;
   logic                nota_fim;
   logic                pausa_fim;
   logic                ultima_nota;

   // Phase-end and last-note decodes
   assign nota_fim    = (timer == ULTIMO_NOTA);
   assign pausa_fim   = (timer == ULTIMO_PAUSA);
   assign ultima_nota = (endereco == limite_reg);

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado <= OCIOSO;
      end else begin
         estado <= prox_estado;
      end
   end

   // Next-state logic; abortar overrides every transition out of a busy state
   always_comb begin
      prox_estado = estado;
      if ((estado != OCIOSO) && abortar) begin
         prox_estado = OCIOSO;
      end else begin
         unique case (estado)
            OCIOSO: begin
               if (iniciar && !abortar) begin
                  prox_estado = ENDERECA;
               end
            end
            ENDERECA: prox_estado = CARREGA;
            CARREGA:  prox_estado = TOCA;
            TOCA: begin
               if (nota_fim) begin
                  prox_estado = PAUSA;
               end
            end
            PAUSA: begin
               if (pausa_fim) begin
                  prox_estado = ultima_nota ? FIM : ENDERECA;
               end
            end
            FIM:      prox_estado = OCIOSO;
            default:  prox_estado = OCIOSO;
         endcase
      end
   end

   // Phase timer: restarts on every state change, idle while in OCIOSO
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         timer <= '0;
      end else if (prox_estado != estado) begin
         timer <= '0;
      end else if (estado != OCIOSO) begin
         timer <= timer + TIMER_W'(1);
      end
   end

   // Last-note index, captured only when a start is accepted
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         limite_reg <= '0;
      end else if ((estado == OCIOSO) && (prox_estado == ENDERECA)) begin
         limite_reg <= limite;
      end
   end

   // Note address: cleared whenever heading idle, advanced after each pause
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         endereco <= '0;
      end else if (prox_estado == OCIOSO) begin
         endereco <= '0;
      end else if ((estado == PAUSA) && (prox_estado == ENDERECA)) begin
         endereco <= endereco + ADDR_W'(1);
      end
   end

   // Buzzer output: ROM data captured leaving CARREGA, held through TOCA, zero elsewhere
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         arduino_out <= '0;
      end else if (prox_estado == TOCA) begin
         if (estado == CARREGA) begin
            arduino_out <= nota_mem;
         end
      end else begin
         arduino_out <= '0;
      end
   end

   // Status flags decoded from the upcoming state so they align with it
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tocando <= 1'b0;
         pronto  <= 1'b0;
      end else begin
         tocando <= (prox_estado != OCIOSO);
         pronto  <= (prox_estado == FIM);
      end
   end

   assign db_estado = estado;

endmodule

// File: tb/tb_escalonador_melodia.sv
// Self-checking bench for escalonador_melodia: directed scenarios plus
// randomized melodies compared against a cycle-indexed arithmetic model.
module tb_escalonador_melodia;

   localparam int unsigned TN = 4;
   localparam int unsigned TP = 2;
   localparam int unsigned AW = 4;
   localparam int unsigned NW = 3;
   localparam int          P  = 2 + TN + TP;

   logic          clock    = 1'b0;
   logic          reset    = 1'b1;
   logic          iniciar  = 1'b0;
   logic          abortar  = 1'b0;
   logic [AW-1:0] limite   = '0;
   logic [NW-1:0] nota_mem;
   logic [AW-1:0] endereco;
   logic [NW-1:0] arduino_out;
   logic          tocando;
   logic          pronto;
   logic [2:0]    db_estado;

   logic [NW-1:0] rom [16];

   int n_checks = 0;
   int n_fail   = 0;
   int cur_t    = 0;

   escalonador_melodia #(
      .TEMPO_NOTA (TN),
      .TEMPO_PAUSA(TP),
      .ADDR_W     (AW),
      .NOTE_W     (NW)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .iniciar    (iniciar),
      .abortar    (abortar),
      .limite     (limite),
      .nota_mem   (nota_mem),
      .endereco   (endereco),
      .arduino_out(arduino_out),
      .tocando    (tocando),
      .pronto     (pronto),
      .db_estado  (db_estado)
   );

   always #5 clock = ~clock;

   // Synchronous ROM: data valid the cycle after the address
   always @(posedge clock) nota_mem <= rom[endereco];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, cur_t, obs, exp);
      end
   endtask

   task automatic expect_idle(input string tag);
      chk({tag, "_estado"},  32'(db_estado),   32'd0);
      chk({tag, "_end"},     32'(endereco),    32'd0);
      chk({tag, "_nota"},    32'(arduino_out), 32'd0);
      chk({tag, "_tocando"}, 32'(tocando),     32'd0);
      chk({tag, "_pronto"},  32'(pronto),      32'd0);
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   // Expected outputs at cycle t after iniciar (t=0) for a melody ending at L,
   // optionally aborted with abortar high during cycle ab.
   task automatic model(input int t, input int L, input int ab,
                        output int st, output int ad, output int nt,
                        output int toc, output int pr, output bit ad_ok);
      int fim_c;
      int n;
      int ph;
      fim_c = (L + 1) * P + 1;
      st = 0; ad = 0; nt = 0; toc = 0; pr = 0; ad_ok = 1'b1;
      if (ab > 0 && t > ab) begin
         // idle after abort
      end else if (t >= 1 && t < fim_c) begin
         n   = (t - 1) / P;
         ph  = (t - 1) % P;
         toc = 1;
         ad  = n;
         if (ph == 0)           st = 1;
         else if (ph == 1)      st = 2;
         else if (ph < 2 + TN)  st = 3;
         else                   st = 4;
         nt = (st == 3) ? int'(rom[n]) : 0;
      end else if (t == fim_c) begin
         st = 5; toc = 1; pr = 1; ad_ok = 1'b0;
      end
   endtask

   // Start a melody and check every cycle; stop_at>0 ends the check early
   task automatic run_melody(input string tag, input int L, input int ab,
                             input int rp, input int lc, input int ln, input int stop_at);
      int last;
      int st, ad, nt, toc, pr;
      bit ad_ok;
      last = ((L + 1) * P + 3 > 40) ? (L + 1) * P + 3 : 40;
      if (stop_at > 0) last = stop_at;
      limite  = AW'(L);
      iniciar = 1'b1;
      abortar = 1'b0;
      cur_t   = 0;
      for (int t = 1; t <= last; t++) begin
         tick();
         cur_t   = t;
         iniciar = (t == rp);
         abortar = (t == ab);
         if (t == lc) limite = AW'(ln);
         model(t, L, ab, st, ad, nt, toc, pr, ad_ok);
         chk({tag, "_estado"},  32'(db_estado),   32'(st));
         if (ad_ok) chk({tag, "_end"}, 32'(endereco), 32'(ad));
         chk({tag, "_nota"},    32'(arduino_out), 32'(nt));
         chk({tag, "_tocando"}, 32'(tocando),     32'(toc));
         chk({tag, "_pronto"},  32'(pronto),      32'(pr));
      end
      iniciar = 1'b0;
      abortar = 1'b0;
   endtask

   initial begin
      int L;
      int ab;
      for (int i = 0; i < 16; i++) rom[i] = '0;

      // Reset state while reset is held
      #3;
      expect_idle("reset");
      @(posedge clock);
      #1;
      reset = 1'b0;
      tick();
      expect_idle("post_reset");

      // Single note
      rom[0] = 3'd5;
      run_melody("single", 0, 0, 0, 0, 0, 0);

      // Three-note melody with a silent middle note
      rom[0] = 3'd3; rom[1] = 3'd0; rom[2] = 3'd6;
      run_melody("three", 2, 0, 0, 0, 0, 0);

      // Abort mid-note
      run_melody("abort", 2, 12, 0, 0, 0, 0);

      // iniciar re-pulse while busy is ignored
      run_melody("repulse", 2, 0, 5, 0, 0, 0);

      // limite change after start is ignored
      run_melody("limchg", 2, 0, 0, 4, 0, 0);

      // iniciar together with abortar in idle is ignored
      iniciar = 1'b1;
      abortar = 1'b1;
      limite  = AW'(3);
      tick();
      iniciar = 1'b0;
      abortar = 1'b0;
      expect_idle("ini_abort");
      tick();
      expect_idle("ini_abort2");

      // Async reset between edges mid-playback, then a clean restart
      run_melody("pre_rst", 2, 0, 0, 0, 0, 20);
      #2;
      reset = 1'b1;
      #1;
      expect_idle("async_rst");
      tick();
      tick();
      reset = 1'b0;
      tick();
      expect_idle("rst_release");
      run_melody("restart", 2, 0, 0, 0, 0, 0);

      // Full address range
      for (int i = 0; i < 16; i++) rom[i] = NW'(i % 8);
      run_melody("full", 15, 0, 0, 0, 0, 0);

      // Randomized melodies, some aborted
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 16; i++) rom[i] = NW'($urandom);
         L  = int'($urandom_range(0, 15));
         ab = 0;
         if ($urandom_range(0, 1) == 1) ab = int'($urandom_range(1, (L + 1) * P));
         run_melody("rand", L, ab, 0, 0, 0, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
